// File: rtl/mips_cache_arbiter.sv
// mips_cache_arbiter
//   Shares one Avalon-MM master port between an instruction cache (read-only
//   fills) and a data cache (fills and write-through stores). Only one bus
//   transaction is in flight at a time. Every output comes from a flop.
//
//   Transaction flow:
//     IDLE  : grant one requester, latch its request, drive the bus.
//     READ  : hold avm_read and the bus fields until waitrequest is low.
//     WRITE : hold avm_write and the bus fields until waitrequest is low.
//     RESP  : one cycle. The requester's *_data_valid is raised on the edge
//             that leaves RESP.
//   Zero-wait latency: a request sampled in IDLE in cycle N gives
//   *_data_valid in cycle N+3. The requester must drop its request in the
//   cycle where it sees data_valid. Otherwise it is granted again.
//
//   Parameter:
//     WAIT_MAX : number of consecutive waitrequest cycles allowed before the
//                transaction is aborted. An abort pulses bus_err, and the
//                requester gets data_valid with data 0.
//
//   Ports:
//     clk, rst                      clock; synchronous active-high reset
//     i_req, i_addr                 instruction-cache miss request
//     i_data_in, i_data_valid       fill word and one-cycle strobe to I-cache
//     d_req, d_write, d_addr,       data-cache request (d_write=1 means a
//     d_writedata, d_byteenable       write-through store)
//     d_data_in, d_data_valid       fill word (0 for a write) and strobe
//     avm_*                         Avalon-MM master signals
//     busy                          high whenever the FSM is not in IDLE
//     bus_err                       one-cycle pulse on a wait timeout
//
//   Build option:
//     MIPS_CACHE_ARB_RR_EN  defined   -> round-robin between the two caches
//                           undefined -> data cache wins simultaneous requests
module mips_cache_arbiter #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data_in,
    output logic        i_data_valid,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_data_in,
    output logic        d_data_valid,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        bus_err
);

    // The wait counter is at least 8 bits wide. It grows when WAIT_MAX needs more.
    localparam int unsigned WaitCalcW = $clog2(WAIT_MAX + 1);
    localparam int unsigned WaitW     = (WaitCalcW > 8) ? WaitCalcW : 8;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(WAIT_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic               gnt_data_q, gnt_data_d;   // 1: data cache owns the bus
    logic [31:0]        rdata_q, rdata_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]        avm_address_q, avm_address_d;
    logic               avm_read_q, avm_read_d;
    logic               avm_write_q, avm_write_d;
    logic [31:0]        avm_writedata_q, avm_writedata_d;
    logic [3:0]         avm_byteenable_q, avm_byteenable_d;
    logic [31:0]        i_data_in_q, i_data_in_d;
    logic               i_data_valid_q, i_data_valid_d;
    logic [31:0]        d_data_in_q, d_data_in_d;
    logic               d_data_valid_q, d_data_valid_d;
    logic               busy_q, busy_d;
    logic               bus_err_q, bus_err_d;
`ifdef MIPS_CACHE_ARB_RR_EN
    logic               rr_q, rr_d;               // 1: data cache is next in line
`endif

    logic               pick_data;
    logic [WaitW-1:0]   wait_inc;
    logic               timeout;

    // Saturating increment. It cannot wrap even if WAIT_MAX is set to 0.
    assign wait_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
    assign timeout  = (wait_inc >= WaitMax);

`ifdef MIPS_CACHE_ARB_RR_EN
    assign pick_data = d_req & (~i_req | rr_q);
`else
    assign pick_data = d_req;
`endif

    always_comb begin
        state_d          = state_q;
        gnt_data_d       = gnt_data_q;
        rdata_d          = rdata_q;
        wait_cnt_d       = wait_cnt_q;
        avm_address_d    = avm_address_q;
        avm_read_d       = avm_read_q;
        avm_write_d      = avm_write_q;
        avm_writedata_d  = avm_writedata_q;
        avm_byteenable_d = avm_byteenable_q;
        // Data buses return to 0 when their strobe is low.
        i_data_in_d      = '0;
        i_data_valid_d   = 1'b0;
        d_data_in_d      = '0;
        d_data_valid_d   = 1'b0;
        bus_err_d        = 1'b0;
`ifdef MIPS_CACHE_ARB_RR_EN
        rr_d             = rr_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    gnt_data_d = pick_data;
                    wait_cnt_d = '0;
`ifdef MIPS_CACHE_ARB_RR_EN
                    rr_d       = ~pick_data;
`endif
                    if (pick_data) begin
                        avm_address_d    = {d_addr[31:2], 2'b00};
                        avm_writedata_d  = d_writedata;
                        avm_byteenable_d = d_byteenable;
                        avm_read_d       = ~d_write;
                        avm_write_d      = d_write;
                        state_d          = d_write ? StWrite : StRead;
                    end else begin
                        avm_address_d    = {i_addr[31:2], 2'b00};
                        avm_writedata_d  = '0;
                        avm_byteenable_d = 4'hF;
                        avm_read_d       = 1'b1;
                        avm_write_d      = 1'b0;
                        state_d          = StRead;
                    end
                end
            end

            StRead, StWrite: begin
                if (!avm_waitrequest) begin
                    rdata_d     = (state_q == StRead) ? avm_readdata : 32'h0;
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    state_d     = StResp;
                end else if (timeout) begin
                    // Abort: the requester is released with data 0.
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    bus_err_d   = 1'b1;
                    wait_cnt_d  = '0;
                    if (gnt_data_q) begin
                        d_data_valid_d = 1'b1;
                    end else begin
                        i_data_valid_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end

            StResp: begin
                if (gnt_data_q) begin
                    d_data_valid_d = 1'b1;
                    d_data_in_d    = rdata_q;
                end else begin
                    i_data_valid_d = 1'b1;
                    i_data_in_d    = rdata_q;
                end
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            gnt_data_q       <= 1'b0;
            rdata_q          <= '0;
            wait_cnt_q       <= '0;
            avm_address_q    <= '0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_writedata_q  <= '0;
            avm_byteenable_q <= '0;
            i_data_in_q      <= '0;
            i_data_valid_q   <= 1'b0;
            d_data_in_q      <= '0;
            d_data_valid_q   <= 1'b0;
            busy_q           <= 1'b0;
            bus_err_q        <= 1'b0;
`ifdef MIPS_CACHE_ARB_RR_EN
            rr_q             <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            gnt_data_q       <= gnt_data_d;
            rdata_q          <= rdata_d;
            wait_cnt_q       <= wait_cnt_d;
            avm_address_q    <= avm_address_d;
            avm_read_q       <= avm_read_d;
            avm_write_q      <= avm_write_d;
            avm_writedata_q  <= avm_writedata_d;
            avm_byteenable_q <= avm_byteenable_d;
            i_data_in_q      <= i_data_in_d;
            i_data_valid_q   <= i_data_valid_d;
            d_data_in_q      <= d_data_in_d;
            d_data_valid_q   <= d_data_valid_d;
            busy_q           <= busy_d;
            bus_err_q        <= bus_err_d;
`ifdef MIPS_CACHE_ARB_RR_EN
            rr_q             <= rr_d;
`endif
        end
    end

    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;
    assign i_data_in      = i_data_in_q;
    assign i_data_valid   = i_data_valid_q;
    assign d_data_in      = d_data_in_q;
    assign d_data_valid   = d_data_valid_q;
    assign busy           = busy_q;
    assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mips_cache_arbiter.sv
// Directed bench for mips_cache_arbiter. WAIT_MAX is set to 4.
// Inputs are driven, and registered outputs are checked, 1 ns after each rising edge.
module tb_mips_cache_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_data_in;
    logic        i_data_valid;
    logic        d_req = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_writedata = '0;
    logic [3:0]  d_byteenable = '0;
    logic [31:0] d_data_in;
    logic        d_data_valid;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        busy;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    mips_cache_arbiter #(.WAIT_MAX(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .i_data_in       (i_data_in),
        .i_data_valid    (i_data_valid),
        .d_req           (d_req),
        .d_write         (d_write),
        .d_addr          (d_addr),
        .d_writedata     (d_writedata),
        .d_byteenable    (d_byteenable),
        .d_data_in       (d_data_in),
        .d_data_valid    (d_data_valid),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .bus_err         (bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Data-side expectation for the two rounds of simultaneous requests.
    logic [1:0] both_exp;

    initial begin
`ifdef MIPS_CACHE_ARB_RR_EN
        both_exp = 2'b10;   // round 0: instruction, round 1: data
`else
        both_exp = 2'b11;   // data wins every time
`endif
        // Reset values
        step();
        step();
        chk1("rst_read", avm_read, 1'b0);
        chk1("rst_write", avm_write, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", bus_err, 1'b0);
        chk1("rst_ivalid", i_data_valid, 1'b0);
        chk1("rst_dvalid", d_data_valid, 1'b0);
        chk("rst_addr", avm_address, 32'h0);
        chk("rst_be", {28'h0, avm_byteenable}, 32'h0);
        rst = 1'b0;
        step();

        // Instruction fill, zero-wait slave, misaligned address
        i_req = 1'b1;
        i_addr = 32'h0000_1003;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'hDEAD_BEEF;
        step();
        chk1("i_read_up", avm_read, 1'b1);
        chk1("i_write_lo", avm_write, 1'b0);
        chk("i_addr_align", avm_address, 32'h0000_1000);
        chk("i_be", {28'h0, avm_byteenable}, 32'hF);
        chk1("i_busy", busy, 1'b1);
        step();
        chk1("i_resp_read", avm_read, 1'b0);
        chk1("i_resp_novalid", i_data_valid, 1'b0);
        chk1("i_resp_busy", busy, 1'b1);
        step();
        chk1("i_valid_n3", i_data_valid, 1'b1);
        chk("i_data", i_data_in, 32'hDEAD_BEEF);
        chk1("i_no_dvalid", d_data_valid, 1'b0);
        chk1("i_idle_busy", busy, 1'b0);
        i_req = 1'b0;
        step();
        chk1("i_valid_pulse", i_data_valid, 1'b0);
        chk("i_data_clr", i_data_in, 32'h0);

        // Data write-through that waits 3 cycles
        d_req = 1'b1;
        d_write = 1'b1;
        d_addr = 32'h20;
        d_writedata = 32'h1234_5678;
        d_byteenable = 4'b0011;
        avm_waitrequest = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            chk1("w_held", avm_write, 1'b1);
            chk("w_be_held", {28'h0, avm_byteenable}, 32'h3);
            chk("w_data_held", avm_writedata, 32'h1234_5678);
            chk("w_addr_held", avm_address, 32'h20);
            chk1("w_no_read", avm_read, 1'b0);
            step();
        end
        chk1("w_still_up", avm_write, 1'b1);
        avm_waitrequest = 1'b0;
        step();
        chk1("w_dropped", avm_write, 1'b0);
        chk1("w_no_early_valid", d_data_valid, 1'b0);
        chk1("w_no_err", bus_err, 1'b0);
        step();
        chk1("w_dvalid", d_data_valid, 1'b1);
        chk("w_ddata_zero", d_data_in, 32'h0);
        chk1("w_no_ivalid", i_data_valid, 1'b0);
        d_req = 1'b0;
        d_write = 1'b0;
        step();
        chk1("w_dvalid_pulse", d_data_valid, 1'b0);

        // Data read. d_addr changes while the slave is waiting.
        d_req = 1'b1;
        d_addr = 32'h40;
        d_byteenable = 4'hF;
        avm_waitrequest = 1'b1;
        avm_readdata = 32'hCAFE_F00D;
        step();
        chk1("r_read_up", avm_read, 1'b1);
        d_addr = 32'h80;
        step();
        chk("r_addr_held", avm_address, 32'h40);
        step();
        chk("r_addr_held2", avm_address, 32'h40);
        avm_waitrequest = 1'b0;
        step();
        chk("r_addr_resp", avm_address, 32'h40);
        chk1("r_read_dn", avm_read, 1'b0);
        avm_readdata = 32'h0;
        step();
        chk1("r_dvalid", d_data_valid, 1'b1);
        chk("r_ddata", d_data_in, 32'hCAFE_F00D);
        d_req = 1'b0;
        step();

        // Simultaneous requests, two rounds
        i_addr = 32'h200;
        d_addr = 32'h100;
        avm_readdata = 32'h1111_1111;
        for (int r = 0; r < 2; r++) begin
            i_req = 1'b1;
            d_req = 1'b1;
            step();
            chk("both_addr", avm_address, both_exp[r] ? 32'h100 : 32'h200);
            step();
            step();
            chk1("both_dvalid", d_data_valid, both_exp[r]);
            chk1("both_ivalid", i_data_valid, ~both_exp[r]);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();

        // Timeout: waitrequest stays high. WAIT_MAX=4.
        i_req = 1'b1;
        i_addr = 32'h300;
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h5555_5555;
        step();
        for (int k = 0; k < 4; k++) begin
            chk1("to_read_up", avm_read, 1'b1);
            chk1("to_no_err", bus_err, 1'b0);
            step();
        end
        chk1("to_read_dn", avm_read, 1'b0);
        chk1("to_err", bus_err, 1'b1);
        chk1("to_ivalid", i_data_valid, 1'b1);
        chk("to_idata", i_data_in, 32'h0);
        chk1("to_no_dvalid", d_data_valid, 1'b0);
        chk1("to_busy", busy, 1'b0);
        i_req = 1'b0;
        step();
        chk1("to_err_pulse", bus_err, 1'b0);
        chk1("to_ivalid_pulse", i_data_valid, 1'b0);

        // Reset during a READ that is waiting
        i_req = 1'b1;
        i_addr = 32'h400;
        step();
        chk1("rr_read_up", avm_read, 1'b1);
        step();
        rst = 1'b1;
        i_req = 1'b0;
        step();
        chk1("rr_read_dn", avm_read, 1'b0);
        chk1("rr_busy", busy, 1'b0);
        chk1("rr_no_ivalid", i_data_valid, 1'b0);
        rst = 1'b0;
        avm_waitrequest = 1'b0;
        step();
        chk1("rr_no_ivalid2", i_data_valid, 1'b0);
        chk1("rr_no_dvalid2", d_data_valid, 1'b0);
        chk1("rr_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
